// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared types and default constants for param_register_file.
//   state_t          : clear sequencer states (ST_IDLE, ST_CLEAR)
//   DEF_DATA_W       : default register width in bits
//   DEF_NUM_REGS     : default register count (power of two, >= 2)
//   DEF_R0_INIT      : default reset/clear value of register 0
package regfile_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_NUM_REGS = 4;
   localparam int DEF_R0_INIT  = 1;

endpackage : regfile_pkg

// File: rtl/param_register_file.sv
// param_register_file -- parameterised register file with one write port,
// two zero-latency read ports with write-first forwarding, and a sequential
// clear engine that walks every register back to its reset value.
//
// Optional feature (macro REGFILE_SHADOW_EN): a shadow bank with one-cycle
// save / restore (both together swap the banks).
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   we/waddr/wdata  write port (ignored while busy)
//   raddr_a/b       read addresses
//   rdata_a/b       combinational read data
//   clr_req         start a sequential clear (ignored while busy)
//   busy            clear in progress
//   save/restore    shadow-bank control (REGFILE_SHADOW_EN only)
module param_register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int R0_INIT  = DEF_R0_INIT,
   localparam int ADDR_W  = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              clr_req,
   output logic              busy
`ifdef REGFILE_SHADOW_EN
   ,
   input  logic              save,
   input  logic              restore
`endif
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   // Reset/clear value of a given register: R0_INIT for register 0, else zero.
   function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
      if (a == {ADDR_W{1'b0}}) begin
         init_val = DATA_W'(R0_INIT);
      end else begin
         init_val = {DATA_W{1'b0}};
      end
   endfunction

   logic [DATA_W-1:0] regs_r [NUM_REGS];
`ifdef REGFILE_SHADOW_EN
   logic [DATA_W-1:0] shadow_r [NUM_REGS];
`endif
   state_t            state_r;
   state_t            state_s;
   logic [ADDR_W-1:0] idx_r;
   logic [ADDR_W-1:0] idx_s;
   logic              busy_s;
   logic              write_en_s;

   assign busy_s = (state_r == ST_CLEAR);
   assign busy   = busy_s;

   // A write only lands when idle; a restore in the same cycle wins over it.
`ifdef REGFILE_SHADOW_EN
   assign write_en_s = we & ~busy_s & ~restore;
`else
   assign write_en_s = we & ~busy_s;
`endif

   // Clear sequencer state and index register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         idx_r   <= {ADDR_W{1'b0}};
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
      end
   end

   // Clear sequencer next-state: one register per cycle, then back to idle.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      case (state_r)
         ST_IDLE: begin
            if (clr_req) begin
               state_s = ST_CLEAR;
               idx_s   = {ADDR_W{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (idx_r == LAST_IDX) begin
               state_s = ST_IDLE;
               idx_s   = {ADDR_W{1'b0}};
            end else begin
               idx_s = idx_r + ADDR_W'(1);
            end
         end
         default: begin
            state_s = ST_IDLE;
            idx_s   = {ADDR_W{1'b0}};
         end
      endcase
   end

   // Register storage: reset, clear walk, shadow save/restore, normal write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= init_val(ADDR_W'(i));
`ifdef REGFILE_SHADOW_EN
            shadow_r[i] <= init_val(ADDR_W'(i));
`endif
         end
      end else if (busy_s) begin
         regs_r[idx_r] <= init_val(idx_r);
      end else begin
`ifdef REGFILE_SHADOW_EN
         // Save captures pre-write contents; save+restore together swap banks.
         if (save) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               shadow_r[i] <= regs_r[i];
            end
         end
         if (restore) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               regs_r[i] <= shadow_r[i];
            end
         end
`endif
         if (write_en_s) begin
            regs_r[waddr] <= wdata;
         end
      end
   end

   // Read ports with write-first forwarding (never forwards clear values).
   always_comb begin
      if (write_en_s && (raddr_a == waddr)) begin
         rdata_a = wdata;
      end else begin
         rdata_a = regs_r[raddr_a];
      end
      if (write_en_s && (raddr_b == waddr)) begin
         rdata_b = wdata;
      end else begin
         rdata_b = regs_r[raddr_b];
      end
   end

endmodule : param_register_file

// File: tb/tb_param_register_file.sv
// tb_param_register_file -- directed self-checking bench for param_register_file
// (default parameters: DATA_W=8, NUM_REGS=4, R0_INIT=1). Shadow-bank scenario
// is included only when REGFILE_SHADOW_EN is defined.
module tb_param_register_file;

   logic       clk;
   logic       rst;
   logic       we;
   logic [1:0] waddr;
   logic [7:0] wdata;
   logic [1:0] raddr_a;
   logic [1:0] raddr_b;
   logic [7:0] rdata_a;
   logic [7:0] rdata_b;
   logic       clr_req;
   logic       busy;
`ifdef REGFILE_SHADOW_EN
   logic       save;
   logic       restore;
`endif

   int n_checks;
   int n_fail;

   param_register_file dut (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr_a (raddr_a),
      .raddr_b (raddr_b),
      .rdata_a (rdata_a),
      .rdata_b (rdata_b),
      .clr_req (clr_req),
      .busy    (busy)
`ifdef REGFILE_SHADOW_EN
      ,
      .save    (save),
      .restore (restore)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single write through the normal port; leaves we low afterwards.
   task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
      we = 1'b1; waddr = a; wdata = d;
      @(posedge clk); #1;
      we = 1'b0;
   endtask

   task automatic load_regs(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
      write_reg(2'd0, d0);
      write_reg(2'd1, d1);
      write_reg(2'd2, d2);
      write_reg(2'd3, d3);
   endtask

   task automatic test_reset;
      logic [7:0] exp [4];
      exp[0] = 8'h01; exp[1] = 8'h00; exp[2] = 8'h00; exp[3] = 8'h00;
      rst = 1'b1;
      #12;
      for (int i = 0; i < 4; i++) begin
         raddr_a = 2'(i);
         #1;
         n_checks++;
         if (rdata_a !== exp[i]) begin
            n_fail++;
            $display("FAIL reset_reg%0d: got %0h expected %0h", i, rdata_a, exp[i]);
         end
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %0b expected 0", busy);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write;
      write_reg(2'd1, 8'hA5);
      write_reg(2'd2, 8'h3C);
      raddr_a = 2'd1; raddr_b = 2'd2;
      #1;
      n_checks++;
      if (rdata_a !== 8'hA5) begin
         n_fail++;
         $display("FAIL write_addr1: got %0h expected a5", rdata_a);
      end
      n_checks++;
      if (rdata_b !== 8'h3C) begin
         n_fail++;
         $display("FAIL write_addr2: got %0h expected 3c", rdata_b);
      end
      raddr_a = 2'd0; raddr_b = 2'd3;
      #1;
      n_checks++;
      if (rdata_a !== 8'h01 || rdata_b !== 8'h00) begin
         n_fail++;
         $display("FAIL write_untouched: got %0h/%0h expected 01/00", rdata_a, rdata_b);
      end
   endtask

   task automatic test_forward;
      we = 1'b1; waddr = 2'd3; wdata = 8'h77; raddr_b = 2'd3; raddr_a = 2'd2;
      #1;
      n_checks++;
      if (rdata_b !== 8'h77) begin
         n_fail++;
         $display("FAIL forward_b: got %0h expected 77", rdata_b);
      end
      n_checks++;
      if (rdata_a !== 8'h3C) begin
         n_fail++;
         $display("FAIL forward_other_port: got %0h expected 3c", rdata_a);
      end
      @(posedge clk); #1;
      we = 1'b0;
      #1;
      n_checks++;
      if (rdata_b !== 8'h77) begin
         n_fail++;
         $display("FAIL forward_stored: got %0h expected 77", rdata_b);
      end
   endtask

   task automatic test_clear;
      logic [7:0] exp [4];
      exp[0] = 8'h01; exp[1] = 8'h00; exp[2] = 8'h00; exp[3] = 8'h00;
      load_regs(8'd9, 8'd8, 8'd7, 8'd6);
      clr_req = 1'b1;
      @(posedge clk); #1;
      // Now in the clear; a write to reg 0 must be ignored and not forwarded.
      clr_req = 1'b0; we = 1'b1; waddr = 2'd0; wdata = 8'h55;
      raddr_a = 2'd0; raddr_b = 2'd1;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++;
         if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_busy_c%0d: got %0b expected 1", k, busy);
         end
         if (k == 0) begin
            n_checks++;
            if (rdata_a !== 8'd9) begin
               n_fail++;
               $display("FAIL clear_no_forward: got %0h expected 09", rdata_a);
            end
         end
         if (k == 1) begin
            n_checks++;
            if (rdata_a !== 8'h01 || rdata_b !== 8'd8) begin
               n_fail++;
               $display("FAIL clear_partial: got %0h/%0h expected 01/08", rdata_a, rdata_b);
            end
         end
         @(posedge clk); #1;
      end
      we = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_done_busy: got %0b expected 0", busy);
      end
      for (int i = 0; i < 4; i++) begin
         raddr_a = 2'(i);
         #1;
         n_checks++;
         if (rdata_a !== exp[i]) begin
            n_fail++;
            $display("FAIL clear_final_reg%0d: got %0h expected %0h", i, rdata_a, exp[i]);
         end
      end
   endtask

   task automatic test_clear_with_write;
      clr_req = 1'b1; we = 1'b1; waddr = 2'd2; wdata = 8'h44;
      @(posedge clk); #1;
      clr_req = 1'b0; we = 1'b0; raddr_a = 2'd2;
      #1;
      n_checks++;
      if (busy !== 1'b1 || rdata_a !== 8'h44) begin
         n_fail++;
         $display("FAIL clr_we_write: got busy=%0b data=%0h expected busy=1 data=44", busy, rdata_a);
      end
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || rdata_a !== 8'h00) begin
         n_fail++;
         $display("FAIL clr_we_cleared: got busy=%0b data=%0h expected busy=0 data=00", busy, rdata_a);
      end
   endtask

   task automatic test_reset_mid_clear;
      logic [7:0] exp [4];
      exp[0] = 8'h01; exp[1] = 8'h00; exp[2] = 8'h00; exp[3] = 8'h00;
      load_regs(8'd9, 8'd8, 8'd7, 8'd6);
      clr_req = 1'b1;
      @(posedge clk); #1;
      clr_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         raddr_a = 2'(i);
         #1;
         n_checks++;
         if (rdata_a !== exp[i]) begin
            n_fail++;
            $display("FAIL midrst_reg%0d: got %0h expected %0h", i, rdata_a, exp[i]);
         end
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_busy: got %0b expected 0", busy);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      // Idle again: a normal write must land and busy stays low.
      write_reg(2'd3, 8'h5A);
      raddr_a = 2'd3;
      #1;
      n_checks++;
      if (busy !== 1'b0 || rdata_a !== 8'h5A) begin
         n_fail++;
         $display("FAIL midrst_idle: got busy=%0b data=%0h expected busy=0 data=5a", busy, rdata_a);
      end
   endtask

`ifdef REGFILE_SHADOW_EN
   task automatic test_shadow;
      load_regs(8'd1, 8'd2, 8'd3, 8'd4);
      save = 1'b1;
      @(posedge clk); #1;
      save = 1'b0;
      write_reg(2'd2, 8'hFF);
      raddr_a = 2'd2;
      #1;
      n_checks++;
      if (rdata_a !== 8'hFF) begin
         n_fail++;
         $display("FAIL shadow_written: got %0h expected ff", rdata_a);
      end
      restore = 1'b1;
      @(posedge clk); #1;
      restore = 1'b0;
      #1;
      n_checks++;
      if (rdata_a !== 8'd3) begin
         n_fail++;
         $display("FAIL shadow_restore: got %0h expected 03", rdata_a);
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1; we = 1'b0; waddr = 2'd0; wdata = 8'h00;
      raddr_a = 2'd0; raddr_b = 2'd0; clr_req = 1'b0;
`ifdef REGFILE_SHADOW_EN
      save = 1'b0; restore = 1'b0;
`endif
      test_reset();
      test_write();
      test_forward();
      test_clear();
      test_clear_with_write();
      test_reset_mid_clear();
`ifdef REGFILE_SHADOW_EN
      test_shadow();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_param_register_file

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning register width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 4, meaning register count (power of two, >= 2).
REQ-003 The block SHALL have parameter R0_INIT, default 1, meaning reset/clear value of register 0; all other registers use 0.
REQ-004 The block SHALL derive local constant ADDR_W = $clog2(NUM_REGS).
REQ-005 The block SHALL have one clock and reset SHALL be asynchronous and active-high, on ports: clk input 1 system clock; rst input 1 async reset.
REQ-006 The block SHALL have port we, input, 1 bit, write enable.
REQ-007 The block SHALL have port waddr, input, ADDR_W bits, write address.
REQ-008 The block SHALL have port wdata, input, DATA_W bits, write data.
REQ-009 The block SHALL have ports raddr_a/raddr_b, input, ADDR_W bits, read addresses.
REQ-010 The block SHALL have ports rdata_a/rdata_b, output, DATA_W bits, read data.
REQ-011 The block SHALL have port clr_req, input, 1 bit, sequential-clear request pulse.
REQ-012 The block SHALL have port busy, output, 1 bit, clear in progress.
REQ-013 The block SHALL have ports save/restore, input, 1 bit each, shadow-bank control (only when REGFILE_SHADOW_EN is defined).

Function
REQ-014 The block SHALL write reg[waddr] <= wdata on posedge clk when we=1 and busy=0; each address SHALL map to its own register.
REQ-015 The block SHALL return rdata_a/rdata_b combinationally (zero latency) from reg[raddr_a]/reg[raddr_b].
REQ-016 The block SHALL forward write-first: with we=1, busy=0, waddr==raddr_x, rdata_x SHALL equal wdata in the same cycle.
REQ-017 The block SHALL run FSM states ST_IDLE and ST_CLEAR; clr_req=1 in ST_IDLE SHALL enter ST_CLEAR next cycle with index 0.
REQ-018 In ST_CLEAR, the block SHALL write reg[idx] <= (idx==0 ? R0_INIT : 0) each cycle and increment idx; after idx==NUM_REGS-1 it SHALL return to ST_IDLE.
REQ-019 The block SHALL hold busy=1 exactly in ST_CLEAR (NUM_REGS cycles); we, clr_req, save and restore SHALL be ignored while busy=1.
REQ-020 On clr_req and we in the same ST_IDLE cycle, the block SHALL perform the write, then clear starting next cycle.
REQ-021 During ST_CLEAR, reads SHALL return current (partially cleared) contents with no forwarding of clear values.

Reset
REQ-022 On rst=1 the block SHALL immediately set reg0=R0_INIT, other registers=0, state=ST_IDLE, idx=0, busy=0, shadow registers equal to register reset values.
REQ-023 The block SHALL abort a clear in progress when rst asserts mid-operation; no partial state SHALL survive.

Configuration
REQ-024 With REGFILE_SHADOW_EN defined, save=1 (busy=0) SHALL copy all registers into a shadow bank in one cycle, capturing pre-write values if we is also active.
REQ-025 With REGFILE_SHADOW_EN defined, restore=1 (busy=0) SHALL load all registers from the shadow bank in one cycle and SHALL override a simultaneous we.
REQ-026 With REGFILE_SHADOW_EN defined, save and restore together SHALL swap register and shadow banks.
REQ-027 Without REGFILE_SHADOW_EN, the block SHALL omit save/restore ports and shadow storage.

Structure
REQ-028 A shared package regfile_pkg SHALL hold typedef enum state_t {ST_IDLE, ST_CLEAR} and default constants for DATA_W, NUM_REGS and R0_INIT.
REQ-029 The block SHALL be a single module with no sub-module.

Verification
REQ-030 The bench SHALL check that after reset, rdata_a at addr 0 = 1 and at addr 1..3 = 0; busy=0.
REQ-031 The bench SHALL check that writing 0xA5 to addr 1 and 0x3C to addr 2 gives reads 1->0xA5 and 2->0x3C, with addr 2 not corrupted by the addr 1 write.
REQ-032 The bench SHALL check that with we=1, waddr=3, wdata=0x77, raddr_b=3, rdata_b=0x77 in the same cycle.
REQ-033 The bench SHALL check that clr_req with regs {9,8,7,6} gives busy=1 for 4 cycles, we=1 ignored during the clear, and final regs {1,0,0,0}.
REQ-034 The bench SHALL check that rst asserted in cycle 2 of a clear gives immediate regs {1,0,0,0}, busy=0, ST_IDLE.
REQ-035 The bench SHALL check (REGFILE_SHADOW_EN) save with regs {1,2,3,4}, then write 0xFF to addr 2, then restore, reads back addr 2 = 3.
